alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Shares the single combinational RV32I ALU between two requesters, e.g. the main execute path and an address-generation/branch-compare helper, using valid/ready handshakes and round-robin arbitration. Results are captured in a registered response slot and returned to the requester that issued the operation. It sits between the requesters and the ALU instance, drives the ALU operand/op inputs, and samples the ALU result.

## Interface
- NUM_REQ, 2, number of requesters; only 2 is supported.
- DATA_W, 32, operand/result width.
- i_clk  in  1  sole clock; all state updates on the rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_req_valid  in  [NUM_REQ]  request pending per requester.
- o_req_ready  out  [NUM_REQ]  grant; request i is accepted on the edge where i_req_valid[i] && o_req_ready[i].
- i_req_op_a, i_req_op_b  in  [NUM_REQ][DATA_W]  operands per requester.
- i_req_alu_op  in  [NUM_REQ][4]  ALU op code per requester: 0 add, 1 sub, 2 slt, 3 sltu, 4 xor, 5 or, 6 and, 7 sll, 8 srl, 9 sra; 10–15 reserved.
- o_rsp_valid  out  [NUM_REQ]  result available for requester i; at most one bit is set.
- i_rsp_ready  in  [NUM_REQ]  requester i consumes the result on the edge where o_rsp_valid[i] && i_rsp_ready[i].
- o_rsp_data  out  DATA_W  result of the held response.
- o_rsp_err  out  1  held response used a reserved op code.
- o_alu_op_a, o_alu_op_b  out  DATA_W  operands driven to the ALU.
- o_alu_op  out  4  op code driven to the ALU.
- i_alu_data  in  DATA_W  ALU result, combinational from the o_alu_* outputs.

## Operation
- **State.** One response slot: `slot_full`, `slot_owner`, `slot_data`, `slot_err`. One round-robin pointer `last_grant`.
- **FSM.** Two states:
  - EMPTY: `slot_full` = 0.
  - FULL: `slot_full` = 1.
- **Space.** `space = !slot_full || (i_rsp_ready[slot_owner] && o_rsp_valid[slot_owner])`. The drain and a new accept may happen on the same edge.
- **Grant.** Combinational; one-hot or zero, and only when `space`.
  - Only one requester valid: that requester is granted.
  - Both valid: grant `!last_grant`.
  - Grant never depends on `o_req_ready`; there are no combinational loops.
- **ALU drive.** `o_alu_*` carry the granted requester's fields. When nothing is granted, they carry requester `!last_grant`'s fields so the ALU does not toggle needlessly.
- **On accept of requester g:**
  - `slot_data` ← `i_alu_data`.
  - `slot_owner` ← g.
  - `slot_err` ← (`i_req_alu_op[g]` ≥ 10).
  - `slot_full` ← 1.
  - `last_grant` ← g.
- **On drain without accept:** `slot_full` ← 0.
- **Reserved op codes.** Accepted normally. The data is whatever the ALU returns (0 by ALU definition), and `o_rsp_err` = 1.
- **Stability rule.** A requester must hold valid and its fields stable until accepted. A valid that is dropped before acceptance is treated as a withdrawal; no error is flagged.
- **Outputs.**
  - `o_rsp_valid[i]` = `slot_full && slot_owner == i`.
  - `o_rsp_data` = `slot_data`; `o_rsp_err` = `slot_err`.
  - Data/err are don't-care when the slot is empty, but are held stable.
- **Reset.** Forces EMPTY, `last_grant` = 1 (so requester 0 wins the first conflict), `slot_data` = 0, `slot_err` = 0, `slot_owner` = 0.
  - All `o_rsp_valid` = 0 and `o_req_ready` = 0 during reset.
  - Reset in the middle of an operation discards any held response.

## Timing
- Request presented in cycle N with space available: `o_req_ready` is high in cycle N; result is visible with `o_rsp_valid` high in cycle N+1.
- Latency is 1 cycle.
- Throughput is 1 result per cycle while the owner holds `i_rsp_ready` = 1.
- Slot FULL and owner not ready: all grants are 0 and both requesters stall. The response is held indefinitely without change.
- Under continuous contention grants alternate 0,1,0,1…, so neither requester waits more than one transaction.
- The combinational path is `i_req_*` → `o_alu_*` → ALU → slot register. It must close in one cycle, together with the ALU delay.

## Structure
- **Shared package `alu_pkg`:**
  - `alu_op_e` enum (ADD=0 … SRA=9).
  - `ALU_OP_W` = 4.
  - `DATA_W` = 32.
  - `ALU_OP_LAST` = 9, used for the reserved-code check.
- **Sub-module `rr_arbiter2`:**
  - Inputs: req[1:0], enable, last_grant.
  - Output: one-hot grant.
  - Purely combinational.
- The FSM and slot register stay in `alu_arbiter`. The ALU itself is instantiated by the parent, not inside this block.

## Test plan
- **Single request.** Req0 = add 5+7, `i_rsp_ready0` = 1 → ready0 high same cycle; next cycle `o_rsp_valid` = 01, data = 12, err = 0.
- **Conflict after reset.** Both valid (req0 sub 10−3, req1 xor 0xF0^0x0F) → req0 granted first (data 7); req1 next cycle (data 0xFF).
- **Back-pressure.** Req1 sra 0x80000000>>4 with `i_rsp_ready1` = 0 for 3 cycles → data 0xF8000000 held stable; both readies 0 throughout; req0 is granted on the cycle ready1 rises.
- **Streaming.** Both valid for 6 cycles with rsp_ready = 1 → grants alternate 0,1,0,1,0,1; one result per cycle; owners match.
- **Reserved op.** Req0 op = 12 → data 0, `o_rsp_err` = 1; the next valid op clears err.
- **Reset mid-operation.** Reset asserted while slot FULL → next cycle `o_rsp_valid` = 00, readies 0; after reset a conflict grants requester 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its request arbiter.
package alu_pkg;

    localparam int DATA_W      = 32;
    localparam int ALU_OP_W    = 4;
    localparam int NUM_REQ     = 2;
    localparam int ALU_OP_LAST = 9;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLT  = 4'd2,
        ALU_SLTU = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_OR   = 4'd5,
        ALU_AND  = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9
    } alu_op_e;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    // Codes above the last defined op are reserved; the ALU returns 0 for them.
    function automatic logic is_reserved_op(input logic [ALU_OP_W-1:0] op);
        return op > ALU_OP_W'(ALU_OP_LAST);
    endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response handshake bundle between the requesters and alu_arbiter.
interface alu_arbiter_if;
    import alu_pkg::*;

    logic [NUM_REQ-1:0]               i_req_valid;
    logic [NUM_REQ-1:0]               o_req_ready;
    logic [NUM_REQ-1:0][DATA_W-1:0]   i_req_op_a;
    logic [NUM_REQ-1:0][DATA_W-1:0]   i_req_op_b;
    logic [NUM_REQ-1:0][ALU_OP_W-1:0] i_req_alu_op;
    logic [NUM_REQ-1:0]               o_rsp_valid;
    logic [NUM_REQ-1:0]               i_rsp_ready;
    logic [DATA_W-1:0]                o_rsp_data;
    logic                             o_rsp_err;

    // Requester side
    modport master (
        output i_req_valid, i_req_op_a, i_req_op_b, i_req_alu_op, i_rsp_ready,
        input  o_req_ready, o_rsp_valid, o_rsp_data, o_rsp_err
    );

    // Arbiter side
    modport slave (
        input  i_req_valid, i_req_op_a, i_req_op_b, i_req_alu_op, i_rsp_ready,
        output o_req_ready, o_rsp_valid, o_rsp_data, o_rsp_err
    );

endinterface

// File: rtl/alu_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter, purely combinational.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       enable,
    input  logic       last_grant,
    output logic [1:0] grant
);

    // Lone requester wins; on conflict the one not served last wins.
    always_comb begin
        grant = 2'b00;
        if (enable) begin
            case (req)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = last_grant ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters with a single
// registered response slot returned to the issuing requester.
module alu_arbiter
    import alu_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_reset,
    alu_arbiter_if.slave        bus,
    output logic [DATA_W-1:0]   o_alu_op_a,
    output logic [DATA_W-1:0]   o_alu_op_b,
    output logic [ALU_OP_W-1:0] o_alu_op,
    input  logic [DATA_W-1:0]   i_alu_data
);

    slot_state_e       state;
    logic              slot_owner;
    logic [DATA_W-1:0] slot_data;
    logic              slot_err;
    logic              last_grant;

    logic              slot_full;
    logic              drain;
    logic              space;
    logic [1:0]        grant;
    logic              accept;
    logic              sel;

    assign slot_full = (state == SLOT_FULL);
    // Owner consumes this edge, so a new result can land in the same edge.
    assign drain     = slot_full && bus.i_rsp_ready[slot_owner] && !i_reset;
    assign space     = !slot_full || drain;

    rr_arbiter2 u_rr (
        .req        (bus.i_req_valid),
        .enable     (space && !i_reset),
        .last_grant (last_grant),
        .grant      (grant)
    );

    assign accept          = |grant;
    assign bus.o_req_ready = grant;

    // Idle ALU inputs follow the next-in-line requester to avoid toggling.
    always_comb begin
        if (grant[1])      sel = 1'b1;
        else if (grant[0]) sel = 1'b0;
        else               sel = !last_grant;
    end

    assign o_alu_op_a = bus.i_req_op_a[sel];
    assign o_alu_op_b = bus.i_req_op_b[sel];
    assign o_alu_op   = bus.i_req_alu_op[sel];

    assign bus.o_rsp_valid[0] = slot_full && (slot_owner == 1'b0) && !i_reset;
    assign bus.o_rsp_valid[1] = slot_full && (slot_owner == 1'b1) && !i_reset;
    assign bus.o_rsp_data     = slot_data;
    assign bus.o_rsp_err      = slot_err;

    // Slot FSM: capture the ALU result on accept, empty on drain.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state      <= SLOT_EMPTY;
            slot_owner <= 1'b0;
            slot_data  <= '0;
            slot_err   <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            case (state)
                SLOT_EMPTY: begin
                    if (accept) begin
                        state      <= SLOT_FULL;
                        slot_owner <= sel;
                        slot_data  <= i_alu_data;
                        slot_err   <= is_reserved_op(bus.i_req_alu_op[sel]);
                        last_grant <= sel;
                    end
                end
                SLOT_FULL: begin
                    if (accept) begin
                        slot_owner <= sel;
                        slot_data  <= i_alu_data;
                        slot_err   <= is_reserved_op(bus.i_req_alu_op[sel]);
                        last_grant <= sel;
                    end else if (drain) begin
                        state <= SLOT_EMPTY;
                    end
                end
                default: state <= SLOT_EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural RV32I ALU attached.
module tb_alu_arbiter;
    import alu_pkg::*;

    logic                clk;
    logic                reset;
    logic [DATA_W-1:0]   alu_a;
    logic [DATA_W-1:0]   alu_b;
    logic [ALU_OP_W-1:0] alu_op;
    logic [DATA_W-1:0]   alu_data;

    int n_checks;
    int n_pass;

    alu_arbiter_if bus();

    alu_arbiter dut (
        .i_clk      (clk),
        .i_reset    (reset),
        .bus        (bus.slave),
        .o_alu_op_a (alu_a),
        .o_alu_op_b (alu_b),
        .o_alu_op   (alu_op),
        .i_alu_data (alu_data)
    );

    function automatic logic [DATA_W-1:0] alu_model(input logic [ALU_OP_W-1:0] op,
                                                    input logic [DATA_W-1:0] a,
                                                    input logic [DATA_W-1:0] b);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return {31'b0, $signed(a) < $signed(b)};
            4'd3:    return {31'b0, a < b};
            4'd4:    return a ^ b;
            4'd5:    return a | b;
            4'd6:    return a & b;
            4'd7:    return a << b[4:0];
            4'd8:    return a >> b[4:0];
            4'd9:    return DATA_W'($signed(a) >>> b[4:0]);
            default: return '0;
        endcase
    endfunction

    always_comb alu_data = alu_model(alu_op, alu_a, alu_b);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic set_req(input int r, input logic [3:0] op,
                           input logic [31:0] a, input logic [31:0] b);
        bus.i_req_alu_op[r] = op;
        bus.i_req_op_a[r]   = a;
        bus.i_req_op_b[r]   = b;
    endtask

    initial begin
        logic [1:0] exp_g;
        logic [1:0] prev_g;
        n_checks = 0;
        n_pass   = 0;
        reset    = 1'b1;
        bus.i_req_valid = 2'b11;
        bus.i_rsp_ready = 2'b11;
        set_req(0, 4'd0, 32'd0, 32'd0);
        set_req(1, 4'd0, 32'd0, 32'd0);

        // Reset: no grants, no responses, cleared data even with requests pending
        tick();
        sample();
        check("rst_ready", 32'(bus.o_req_ready), 32'h0);
        check("rst_rsp_valid", 32'(bus.o_rsp_valid), 32'h0);
        check("rst_data", bus.o_rsp_data, 32'h0);
        check("rst_err", 32'(bus.o_rsp_err), 32'h0);
        tick();

        // Conflict after reset: req0 first, then req1
        reset = 1'b0;
        bus.i_req_valid = 2'b11;
        set_req(0, 4'd1, 32'd10, 32'd3);
        set_req(1, 4'd4, 32'hF0, 32'h0F);
        sample();
        check("conf_ready0", 32'(bus.o_req_ready), 32'h1);
        check("conf_alu_a", alu_a, 32'd10);
        tick();
        bus.i_req_valid = 2'b10;
        sample();
        check("conf_rsp0_valid", 32'(bus.o_rsp_valid), 32'h1);
        check("conf_rsp0_data", bus.o_rsp_data, 32'd7);
        check("conf_ready1", 32'(bus.o_req_ready), 32'h2);
        tick();
        bus.i_req_valid = 2'b00;
        sample();
        check("conf_rsp1_valid", 32'(bus.o_rsp_valid), 32'h2);
        check("conf_rsp1_data", bus.o_rsp_data, 32'hFF);
        tick();

        // Streaming: grants alternate 0,1,0,... with one result per cycle
        bus.i_req_valid = 2'b11;
        set_req(0, 4'd0, 32'd100, 32'd23);
        set_req(1, 4'd5, 32'h0F, 32'h30);
        prev_g = 2'b00;
        for (int i = 0; i < 6; i++) begin
            exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
            sample();
            check($sformatf("stream_grant%0d", i), 32'(bus.o_req_ready), 32'(exp_g));
            if (i > 0) begin
                check($sformatf("stream_owner%0d", i), 32'(bus.o_rsp_valid), 32'(prev_g));
                check($sformatf("stream_data%0d", i), bus.o_rsp_data,
                      prev_g[0] ? 32'd123 : 32'h3F);
            end
            prev_g = exp_g;
            tick();
        end
        bus.i_req_valid = 2'b00;
        sample();
        check("stream_last_owner", 32'(bus.o_rsp_valid), 32'h2);
        check("stream_last_data", bus.o_rsp_data, 32'h3F);
        tick();

        // Single request: add 5+7
        bus.i_req_valid = 2'b01;
        set_req(0, 4'd0, 32'd5, 32'd7);
        sample();
        check("single_ready", 32'(bus.o_req_ready), 32'h1);
        tick();
        bus.i_req_valid = 2'b00;
        sample();
        check("single_rsp_valid", 32'(bus.o_rsp_valid), 32'h1);
        check("single_data", bus.o_rsp_data, 32'd12);
        check("single_err", 32'(bus.o_rsp_err), 32'h0);
        tick();

        // Back-pressure: req1 sra held while its owner stalls
        bus.i_req_valid = 2'b10;
        bus.i_rsp_ready = 2'b00;
        set_req(1, 4'd9, 32'h8000_0000, 32'd4);
        sample();
        check("bp_ready1", 32'(bus.o_req_ready), 32'h2);
        tick();
        bus.i_req_valid = 2'b01;
        set_req(0, 4'd0, 32'd1, 32'd1);
        for (int i = 0; i < 3; i++) begin
            sample();
            check($sformatf("bp_hold_valid%0d", i), 32'(bus.o_rsp_valid), 32'h2);
            check($sformatf("bp_hold_data%0d", i), bus.o_rsp_data, 32'hF800_0000);
            check($sformatf("bp_hold_ready%0d", i), 32'(bus.o_req_ready), 32'h0);
            tick();
        end
        bus.i_rsp_ready = 2'b10;
        sample();
        check("bp_release_ready0", 32'(bus.o_req_ready), 32'h1);
        check("bp_release_valid", 32'(bus.o_rsp_valid), 32'h2);
        tick();
        bus.i_req_valid = 2'b00;
        bus.i_rsp_ready = 2'b11;
        sample();
        check("bp_next_valid", 32'(bus.o_rsp_valid), 32'h1);
        check("bp_next_data", bus.o_rsp_data, 32'd2);
        tick();

        // Reserved op: data 0 with err, next good op clears err
        bus.i_req_valid = 2'b01;
        set_req(0, 4'd12, 32'd5, 32'd7);
        sample();
        check("resv_ready", 32'(bus.o_req_ready), 32'h1);
        tick();
        set_req(0, 4'd6, 32'h0F, 32'h3C);
        sample();
        check("resv_data", bus.o_rsp_data, 32'h0);
        check("resv_err", 32'(bus.o_rsp_err), 32'h1);
        check("resv_valid", 32'(bus.o_rsp_valid), 32'h1);
        tick();
        bus.i_req_valid = 2'b00;
        sample();
        check("resv_clear_data", bus.o_rsp_data, 32'h0C);
        check("resv_clear_err", 32'(bus.o_rsp_err), 32'h0);
        tick();

        // Reset while the slot is full discards the response
        bus.i_req_valid = 2'b10;
        bus.i_rsp_ready = 2'b00;
        set_req(1, 4'd0, 32'd1, 32'd2);
        tick();
        bus.i_req_valid = 2'b00;
        sample();
        check("mid_full_valid", 32'(bus.o_rsp_valid), 32'h2);
        check("mid_full_data", bus.o_rsp_data, 32'd3);
        tick();
        reset = 1'b1;
        bus.i_req_valid = 2'b11;
        sample();
        check("mid_rst_valid", 32'(bus.o_rsp_valid), 32'h0);
        check("mid_rst_ready", 32'(bus.o_req_ready), 32'h0);
        tick();
        reset = 1'b0;
        bus.i_rsp_ready = 2'b11;
        set_req(0, 4'd1, 32'd10, 32'd3);
        set_req(1, 4'd4, 32'hF0, 32'h0F);
        sample();
        check("post_rst_valid", 32'(bus.o_rsp_valid), 32'h0);
        check("post_rst_grant", 32'(bus.o_req_ready), 32'h1);
        tick();
        bus.i_req_valid = 2'b00;
        sample();
        check("post_rst_owner", 32'(bus.o_rsp_valid), 32'h1);
        check("post_rst_data", bus.o_rsp_data, 32'd7);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
